// File: rtl/drone_mix_pkg.sv
// Shared widths, FSM encoding and quad-X mix-sign table for the motor mix scheduler.
// The mixing helper sign-extends offsets so negating -128 cannot wrap.
package drone_mix_pkg;

  localparam int OFFSET_W = 8;
  localparam int ACC_W    = 11;
  localparam int CMD_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MIX    = 2'd1,
    ST_COMMIT = 2'd2
  } mix_state_e;

  // Per motor negate bits {yaw, roll, pitch}; throttle is always added.
  localparam logic [3:0][2:0] MIX_NEG = {3'b001, 3'b111, 3'b010, 3'b100};

  function automatic logic signed [ACC_W-1:0] sext(input logic [OFFSET_W-1:0] x);
    return $signed({{(ACC_W-OFFSET_W){x[OFFSET_W-1]}}, x});
  endfunction

  // ofs[0]=throttle, ofs[1]=pitch, ofs[2]=roll, ofs[3]=yaw
  function automatic logic signed [ACC_W-1:0] mix_sum(
    input logic [CMD_W-1:0]               base,
    input logic [3:0][OFFSET_W-1:0]       ofs,
    input logic [2:0]                     neg
  );
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] term;
    acc = $signed({{(ACC_W-CMD_W){1'b0}}, base}) + sext(ofs[0]);
    for (int a = 0; a < 3; a++) begin
      term = sext(ofs[a+1]);
      acc  = neg[a] ? (acc - term) : (acc + term);
    end
    return acc;
  endfunction

endpackage

// File: rtl/mix_clamp.sv
// Clamps one signed mix sum into the MIN_CMD..MAX_CMD command range.
// With MIX_SLEW_LIMIT_EN defined it also limits the step away from the current output.
module mix_clamp
  import drone_mix_pkg::*;
#(
  parameter int MIN_CMD   = 0,
  parameter int MAX_CMD   = 200,
  parameter int SLEW_STEP = 10
) (
  input  logic signed [ACC_W-1:0] sum,
  input  logic [CMD_W-1:0]        current,
  output logic [CMD_W-1:0]        cmd
);

  localparam logic signed [ACC_W-1:0] MIN_S = ACC_W'(MIN_CMD);
  localparam logic signed [ACC_W-1:0] MAX_S = ACC_W'(MAX_CMD);

  logic [CMD_W-1:0] target;

  always_comb begin
    target = sum[CMD_W-1:0];
    if (sum < MIN_S) begin
      target = CMD_W'(MIN_CMD);
    end else if (sum > MAX_S) begin
      target = CMD_W'(MAX_CMD);
    end
  end

`ifdef MIX_SLEW_LIMIT_EN
  logic [CMD_W+1:0] t_w, c_w, step_w;

  // Current and target are both in range, so stepping toward target stays in range.
  always_comb begin
    t_w    = {2'b00, target};
    c_w    = {2'b00, current};
    step_w = (CMD_W+2)'(SLEW_STEP);
    cmd    = target;
    if (t_w > c_w + step_w) begin
      cmd = CMD_W'(c_w + step_w);
    end else if (t_w + step_w < c_w) begin
      cmd = CMD_W'(c_w - step_w);
    end
  end
`else
  logic [CMD_W-1:0] unused_current;
  assign unused_current = current ^ CMD_W'(SLEW_STEP);
  assign cmd = target;
`endif

endmodule

// File: rtl/motor_mix_scheduler.sv
// Time-multiplexed quad-X motor mixer: one motor per cycle, all four outputs committed together.
// Optional slew limiting is enabled with the MIX_SLEW_LIMIT_EN macro.
//
// Handshake: a command is accepted on a rising edge where cmd_valid & cmd_ready; cmd_ready is
// high only in IDLE, offsets are sampled on that edge and cmd_valid is ignored until IDLE returns.
module motor_mix_scheduler
  import drone_mix_pkg::*;
#(
  parameter int BASE_CMD  = 50,
  parameter int MIN_CMD   = 0,
  parameter int MAX_CMD   = 200,
  parameter int SLEW_STEP = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [OFFSET_W-1:0] throttle_offset,
  input  logic [OFFSET_W-1:0] pitch_offset,
  input  logic [OFFSET_W-1:0] roll_offset,
  input  logic [OFFSET_W-1:0] yaw_offset,
  output logic [CMD_W-1:0]    motor0_cmd,
  output logic [CMD_W-1:0]    motor1_cmd,
  output logic [CMD_W-1:0]    motor2_cmd,
  output logic [CMD_W-1:0]    motor3_cmd,
  output logic                mix_done,
  output logic                busy,
  output mix_state_e          dbg_state
);

  mix_state_e                 state_q, state_d;
  logic [1:0]                 idx_q;
  logic [3:0][OFFSET_W-1:0]   ofs_q;
  logic [3:0][CMD_W-1:0]      shadow_q;
  logic [3:0][CMD_W-1:0]      motor_q;
  logic                       accept;
  logic signed [ACC_W-1:0]    sum;
  logic [CMD_W-1:0]           mixed;

  assign accept = cmd_valid & cmd_ready;
  assign sum    = mix_sum(CMD_W'(BASE_CMD), ofs_q, MIX_NEG[idx_q]);

  mix_clamp #(
    .MIN_CMD  (MIN_CMD),
    .MAX_CMD  (MAX_CMD),
    .SLEW_STEP(SLEW_STEP)
  ) u_clamp (
    .sum    (sum),
    .current(motor_q[idx_q]),
    .cmd    (mixed)
  );

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_d = ST_MIX;
      end
      ST_MIX:    if (idx_q == 2'd3) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= 2'd0;
      ofs_q    <= '0;
      shadow_q <= '0;
      motor_q  <= {4{CMD_W'(MIN_CMD)}};
      mix_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      mix_done <= (state_q == ST_COMMIT);
      if (accept) begin
        ofs_q <= {yaw_offset, roll_offset, pitch_offset, throttle_offset};
        idx_q <= 2'd0;
      end
      if (state_q == ST_MIX) begin
        shadow_q[idx_q] <= mixed;
        idx_q           <= idx_q + 2'd1;
      end
      if (state_q == ST_COMMIT) motor_q <= shadow_q;
    end
  end

  assign motor0_cmd = motor_q[0];
  assign motor1_cmd = motor_q[1];
  assign motor2_cmd = motor_q[2];
  assign motor3_cmd = motor_q[3];
  assign dbg_state  = state_q;

endmodule
